// File: rtl/w0rm_peripheral_gpio.sv
// GPIO peripheral for the W0RM data bus: eight-register window with direction, output latch,
// set/clear/toggle strobes and a two-flop synchronized input view of the pads.
module w0rm_peripheral_gpio #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    GPIO_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  mem_clk,
  input  logic                  cpu_reset,
  input  logic                  mem_valid_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  mem_valid_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  inout  wire  [GPIO_WIDTH-1:0] pin_gpio_pad
);

  localparam logic [2:0] OFF_IN  = 3'd0;
  localparam logic [2:0] OFF_DIR = 3'd1;
  localparam logic [2:0] OFF_OUT = 3'd2;
  localparam logic [2:0] OFF_SET = 3'd3;
  localparam logic [2:0] OFF_CLR = 3'd4;
  localparam logic [2:0] OFF_TGL = 3'd5;

  logic [GPIO_WIDTH-1:0] dir_q, dir_d;
  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  in_window;
  logic                  accept;
  logic [GPIO_WIDTH-1:0] wdata;
  logic [GPIO_WIDTH-1:0] rdata;

  // Addresses below BASE_ADDR wrap to a huge offset and so fall outside the window.
  assign offset    = mem_addr_i - BASE_ADDR;
  assign in_window = (offset < ADDR_WIDTH'(8));
  assign accept    = mem_valid_i && (mem_read_i || mem_write_i) && in_window;
  assign wdata     = mem_data_i[GPIO_WIDTH-1:0];

  always_comb begin
    dir_d = dir_q;
    out_d = out_q;
    rdata = '0;
    if (accept) begin
      case (offset[2:0])
        OFF_IN: begin
          if (!mem_write_i) rdata = sync2_q;
        end
        OFF_DIR: begin
          if (mem_write_i) dir_d = wdata;
          rdata = dir_d;
        end
        OFF_OUT: begin
          if (mem_write_i) out_d = wdata;
          rdata = out_d;
        end
        OFF_SET: begin
          if (mem_write_i) out_d = out_q | wdata;
          rdata = out_d;
        end
        OFF_CLR: begin
          if (mem_write_i) out_d = out_q & ~wdata;
          rdata = out_d;
        end
        OFF_TGL: begin
          if (mem_write_i) out_d = out_q ^ wdata;
          rdata = out_d;
        end
        default: rdata = '0;
      endcase
    end
    rsp_vld_d  = accept;
    rsp_data_d = DATA_WIDTH'(rdata);
  end

  always_ff @(posedge mem_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      dir_q      <= '0;
      out_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      dir_q      <= dir_d;
      out_q      <= out_d;
      sync1_q    <= pin_gpio_pad;
      sync2_q    <= sync1_q;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign mem_valid_o = rsp_vld_q;
  assign mem_data_o  = rsp_data_q;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pad
    assign pin_gpio_pad[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

endmodule

// File: tb/tb_w0rm_peripheral_gpio.sv
// Scoreboard bench for w0rm_peripheral_gpio in an 8-bit configuration; the bench holds pads [3:0] at 0x3.
module tb_w0rm_peripheral_gpio;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_i = 1'b0;
  logic       read_i = 1'b0;
  logic       write_i = 1'b0;
  logic [7:0] addr_i = '0;
  logic [7:0] data_i = '0;
  logic       valid_o;
  logic [7:0] data_o;
  wire  [7:0] pad;

  assign pad[3:0] = 4'h3;

  w0rm_peripheral_gpio #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .GPIO_WIDTH(8), .BASE_ADDR(8'h00)
  ) dut (
    .mem_clk(clk), .cpu_reset(rst),
    .mem_valid_i(valid_i), .mem_read_i(read_i), .mem_write_i(write_i),
    .mem_addr_i(addr_i), .mem_data_i(data_i),
    .mem_valid_o(valid_o), .mem_data_o(data_o),
    .pin_gpio_pad(pad)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit mon_en = 1'b1;

  typedef struct {
    logic [7:0] data;
    int         due;
    string      tag;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Responses are matched in order against the queue, including the cycle they must land on.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {24'h0, data_o}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.tag, "_data"}, {24'h0, data_o}, {24'h0, e.data});
          chk({e.tag, "_cycle"}, cyc, e.due);
        end
      end else begin
        chk("idle_data", {24'h0, data_o}, 32'h0);
        if (sb.size() != 0 && sb[0].due < cyc) begin
          chk({sb[0].tag, "_missing"}, 0, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    valid_i = 1'b1; read_i = rd; write_i = wr; addr_i = a; data_i = d;
  endtask

  task automatic req(input string tag, input logic rd, input logic wr, input logic [7:0] a,
                     input logic [7:0] d, input logic [7:0] exp);
    exp_t e;
    drive(rd, wr, a, d);
    e.data = exp; e.due = cyc + 1; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      valid_i = 1'b0; read_i = 1'b0; write_i = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", {31'h0, valid_o}, 32'h0);

    req("rd_dir0", 1, 0, 8'h01, 8'h00, 8'h00);
    req("rd_out0", 1, 0, 8'h02, 8'h00, 8'h00);
    idle(2);

    req("wr_dir", 0, 1, 8'h01, 8'hF0, 8'hF0);
    req("wr_out", 0, 1, 8'h02, 8'hA5, 8'hA5);
    idle(4);
    chk("pad_hi", {28'h0, pad[7:4]}, 32'hA);
    req("rd_in", 1, 0, 8'h00, 8'h00, 8'hA3);

    req("wr_set", 0, 1, 8'h03, 8'h0F, 8'hAF);
    req("wr_clr", 0, 1, 8'h04, 8'h80, 8'h2F);
    req("wr_tgl", 0, 1, 8'h05, 8'h21, 8'h0E);
    req("rd_out", 1, 0, 8'h02, 8'h00, 8'h0E);
    req("rd_set", 1, 0, 8'h03, 8'h00, 8'h0E);
    idle(2);
    chk("pad_hi_tgl", {28'h0, pad[7:4]}, 32'h0);

    drive(0, 1, 8'h08, 8'hFF);
    drive(1, 0, 8'h08, 8'h00);
    drive(0, 0, 8'h02, 8'hFF);
    req("wr_in", 0, 1, 8'h00, 8'h55, 8'h00);
    req("wr_rsv", 0, 1, 8'h06, 8'h77, 8'h00);
    idle(2);
    req("rd_out_kept", 1, 0, 8'h02, 8'h00, 8'h0E);
    req("rd_dir_kept", 1, 0, 8'h01, 8'h00, 8'hF0);
    idle(2);

    req("b2b_dir", 1, 0, 8'h01, 8'h00, 8'hF0);
    req("b2b_out", 1, 0, 8'h02, 8'h00, 8'h0E);
    req("b2b_rsv", 1, 0, 8'h06, 8'h00, 8'h00);
    req("rdwr_out", 1, 1, 8'h02, 8'h3C, 8'h3C);
    idle(3);

    mon_en = 1'b0;
    drive(1, 0, 8'h01, 8'h00);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", {31'h0, valid_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_drop_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_drop_data", {24'h0, data_o}, 32'h0);
    valid_i = 1'b0; read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    req("post_rst_dir", 1, 0, 8'h01, 8'h00, 8'h00);
    req("post_rst_out", 1, 0, 8'h02, 8'h00, 8'h00);
    idle(1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
